// File: rtl/spi_target.sv
// SPI mode-0 target with a single-entry TX buffer, CS-framed FSM and status strobes.
// Optional end-of-transaction interrupt: define SPI_TARGET_IRQ_EN to enable irq_o.
module spi_target #(
    parameter logic [7:0] TX_DUMMY = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       spi_clk_i,
    input  logic       spi_csn_i,
    input  logic       spi_sdi_i,
    output logic       spi_sdo_o,
    output logic       spi_sdo_en_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_underrun_o,
    output logic       abort_o,
    output logic       irq_o
);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_e;

    state_e     state_q, state_d;
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] csn_sync_q, csn_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       tx_ready_q, tx_ready_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       abort_q, abort_d;
    logic       sdo_en_q, sdo_en_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall, csn_s;
    logic       load, tx_write;
`ifdef SPI_TARGET_IRQ_EN
    logic       irq_q, irq_d;
`endif

    // Bit 1 is the synchronized level, bit 2 the delayed copy for edge detection.
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_rise  = csn_sync_q[1] & ~csn_sync_q[2];
    assign cs_fall  = ~csn_sync_q[1] & csn_sync_q[2];
    assign csn_s    = csn_sync_q[1];
    assign tx_write = tx_valid_i & tx_ready_q;

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[1:0], spi_clk_i};
        csn_sync_d  = {csn_sync_q[1:0], spi_csn_i};
        sdi_sync_d  = {sdi_sync_q[0], spi_sdi_i};
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        cnt_d       = cnt_q;
        byte_done_d = byte_done_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;
`ifdef SPI_TARGET_IRQ_EN
        irq_d       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (csn_s) state_d = ARMED;
            end
            ARMED: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    load        = 1'b1;
                    cnt_d       = 3'd0;
                    byte_done_d = 1'b0;
                    rx_shift_d  = 8'h00;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = ARMED;
                    abort_d = (cnt_q != 3'd0);
`ifdef SPI_TARGET_IRQ_EN
                    irq_d   = 1'b1;
`endif
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], sdi_sync_q[1]};
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d   = rx_shift_d;
                        rx_valid_d  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_done_q) begin
                        load        = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_DUMMY;
                underrun_d = 1'b1;
            end
        end

        // A write in the same cycle as a load lands after it, so it waits for the next load.
        if (tx_write) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end

        tx_ready_d = ~buf_full_d;
        sdo_en_d   = (state_d == ACTIVE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            sck_sync_q  <= 3'd0;
            csn_sync_q  <= 3'd0;
            sdi_sync_q  <= 2'd0;
            buf_q       <= 8'h00;
            buf_full_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            cnt_q       <= 3'd0;
            byte_done_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            sdo_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            csn_sync_q  <= csn_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            tx_ready_q  <= tx_ready_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            byte_done_q <= byte_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
            sdo_en_q    <= sdo_en_d;
        end
    end

`ifdef SPI_TARGET_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign spi_sdo_o     = tx_shift_q[7];
    assign spi_sdo_en_o  = sdo_en_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;
    assign abort_o       = abort_q;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter TX_DUMMY, default 8'hFF: byte shifted out when no host-side TX data is pending.
REQ-002 SHALL have port clk_i  in  1  system clock; all internal logic in this domain.
REQ-003 SHALL have port rstn_i  in  1  reset; synchronous and active-low.
REQ-004 SHALL have ports spi_clk_i, spi_csn_i, spi_sdi_i  in  1 each  SPI bus from external host; asynchronous to clk_i.
REQ-005 SHALL have ports spi_sdo_o  out  1  serial data to host; spi_sdo_en_o  out  1  output enable for the pad tristate.
REQ-006 SHALL have ports tx_data_i  in  8, tx_valid_i  in  1, tx_ready_o  out  1  byte to send, valid/ready handshake.
REQ-007 SHALL have ports rx_data_o  out  8, rx_valid_o  out  1  received byte, single-cycle strobe, no backpressure.
REQ-008 SHALL have ports tx_underrun_o  out  1, abort_o  out  1, irq_o  out  1  single-cycle status strobes.

Function
REQ-009 SHALL pass spi_clk_i, spi_csn_i and spi_sdi_i through 2-FF synchronizers, plus one extra stage on spi_clk_i and spi_csn_i for edge detection.
REQ-010 SHALL implement SPI mode 0 only, MSB first: sample on SCK rising edge, shift on SCK falling edge.
REQ-011 SHALL support SCK <= clk_i/6; host SHALL provide >= 4 clk_i cycles from CS low to first SCK edge.
REQ-012 SHALL hold a single-entry TX buffer: tx_ready_o = buffer empty; write on tx_valid_i & tx_ready_o.
REQ-013 SHALL use FSM states IDLE, ARMED, ACTIVE: IDLE -> ARMED on sync CS high; ARMED -> ACTIVE on sync CS falling edge; ACTIVE -> ARMED on sync CS rising edge.
REQ-014 SHALL on entry to ACTIVE load shift register from TX buffer (emptying it) or TX_DUMMY if empty, bit counter = 0, spi_sdo_o = shift register MSB.
REQ-015 SHALL drive spi_sdo_en_o = 1 only in ACTIVE.
REQ-016 SHALL on each detected SCK rising edge shift synced SDI into the RX shift register LSB and increment the 3-bit bit counter (wraps 7 -> 0).
REQ-017 SHALL on the rising edge with counter == 7 update rx_data_o and pulse rx_valid_o in the next clk_i cycle (<= 4 clk_i cycles after the SCK edge).
REQ-018 SHALL on each falling edge shift TX left; on the falling edge after a completed byte reload from the buffer or TX_DUMMY instead.
REQ-019 SHALL pulse tx_underrun_o for one cycle whenever TX_DUMMY is loaded because the buffer was empty.
REQ-020 SHALL load the pre-write buffer content when a tx_valid_i write coincides with a byte load; the new byte stays buffered for the next load.
REQ-021 SHALL on CS rising edge with counter != 0 discard the partial byte, suppress rx_valid_o and pulse abort_o for one cycle.
REQ-022 SHALL keep rx_data_o stable between rx_valid_o strobes.

Reset
REQ-023 SHALL on rstn_i = 0 at a clk_i edge enter IDLE, clear synchronizers, counter, shift registers and TX buffer.
REQ-024 SHALL hold all outputs 0 during reset except tx_ready_o = 1 once out of reset (buffer empty).
REQ-025 SHALL after reset mid-transfer (CS already low) stay IDLE, SDO disabled, until CS seen high then falling.

Configuration
REQ-026 SHALL with macro SPI_TARGET_IRQ_EN defined pulse irq_o one cycle on every sync CS rising edge in ACTIVE (end of transaction, incl. aborts).
REQ-027 SHALL with SPI_TARGET_IRQ_EN undefined tie irq_o to 0 and implement no IRQ logic.

Verification
REQ-028 SHALL cover: tx 8'hA5 buffered, CS low, 8 SCK (clk_i/8), host sends 8'h3C -> SDO bits 1,0,1,0,0,1,0,1; rx_data_o = 8'h3C, one rx_valid_o pulse.
REQ-029 SHALL cover: empty buffer, 1-byte transfer, host sends 8'h00 -> SDO 8'hFF, tx_underrun_o one pulse, rx_data_o = 8'h00.
REQ-030 SHALL cover: 2-byte transfer, tx 8'h11 then 8'h22 written during byte 1 -> SDO 8'h11, 8'h22; two rx_valid_o pulses.
REQ-031 SHALL cover: CS high after 5 SCK -> abort_o one pulse, no rx_valid_o, next transaction of 8'h5A received correctly.
REQ-032 SHALL cover: rstn_i low for 2 cycles mid-byte with CS low -> spi_sdo_en_o = 0 until CS high then low; no rx_valid_o.
REQ-033 SHALL cover: SPI_TARGET_IRQ_EN defined -> irq_o one pulse per CS rise; undefined -> irq_o constant 0.
